duty_silencer: RTL

- Sits directly downstream of the modulation stage. Consumes the per-transducer modulated duty array and produces a slew-limited duty array for the PWM generators.
- On each update strobe, snapshots all targets. A single shared step-limiter is time-multiplexed across transducers, one per clock, so each duty moves toward its target by at most STEP per update.
- Suppresses audible artefacts from abrupt amplitude changes ("silent mode").

---
 rtl/duty_silencer_if.sv | 23 ++
 rtl/duty_silencer.sv | 84 ++++++++
 2 files changed

// File: rtl/duty_silencer_if.sv
// Bus between the modulation stage and the duty silencer.
// Targets and controls go in; slewed duties and status come out.
interface duty_silencer_if #(
  parameter int TRANS_NUM = 249
);
  logic                       update;
  logic                       silent_en;
  logic [7:0]                 step;
  logic [TRANS_NUM-1:0][7:0]  duty_in;
  logic [TRANS_NUM-1:0][7:0]  duty_out;
  logic                       busy;
  logic                       overrun;

  modport master (
    output update, silent_en, step, duty_in,
    input  duty_out, busy, overrun
  );

  modport slave (
    input  update, silent_en, step, duty_in,
    output duty_out, busy, overrun
  );
endinterface

// File: rtl/duty_silencer.sv
// Slew-limits the per-transducer duty array with one shared step limiter
// that walks the channels one per clock after each update strobe.
module duty_silencer #(
  parameter int TRANS_NUM = 249,
  parameter int IDX_W     = $clog2(TRANS_NUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  duty_silencer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TRANS_NUM - 1);

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic [TRANS_NUM-1:0][7:0]  snap;
  logic [TRANS_NUM-1:0][7:0]  duty_r;
  logic [7:0]                 step_l;
  logic                       silent_l;
  logic                       overrun_r;

  logic [7:0]                 cur, tgt, nxt;
  logic signed [8:0]          diff;
  logic [8:0]                 mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.update) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared limiter: result always lies between cur and tgt, so no wrap.
  assign cur = duty_r[idx];
  assign tgt = snap[idx];

  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[8] ? 9'(-diff) : 9'(diff);
    nxt  = tgt;
    if (silent_l && (mag > {1'b0, step_l})) begin
      if (!diff[8]) nxt = cur + step_l;
      else          nxt = cur - step_l;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      snap      <= '0;
      duty_r    <= '0;
      step_l    <= 8'd1;
      silent_l  <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= bus.update && (state == RUN);
      if (state == IDLE) begin
        if (bus.update) begin
          snap     <= bus.duty_in;
          step_l   <= (bus.step == 8'd0) ? 8'd1 : bus.step;
          silent_l <= bus.silent_en;
          idx      <= '0;
        end
      end else begin
        duty_r[idx] <= nxt;
        idx         <= (idx == LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  assign bus.duty_out = duty_r;
  assign bus.busy     = (state == RUN);
  assign bus.overrun  = overrun_r;

endmodule
